pe_instr_loader: RTL and testbench
==================================

Name: pe_instr_loader

Overview:
- Memory-mapped instruction loader for a processing element. It assembles InstrWidth-bit instructions from DataWidth-bit host bus writes and commits them into an on-chip instruction buffer of 2^AddrWidth entries.
- The PE reads the buffer through a registered fetch port. The host can read back committed entries and a status register.
- Parametrised successor of the fixed 4x32-bit, single-trigger PE instruction write path. Adds configurable word count, readback, per-entry valid tracking, busy/error reporting and shader-reset clearing.

Parameters:
- DataWidth, 32, host bus word width.
- WordsPerInstr, 4, bus words per instruction (2..8); InstrWidth = DataWidth*WordsPerInstr.
- AddrWidth, 5, instruction buffer index width; depth = 2^AddrWidth.

Ports:
- iClk  in  1  clock.
- iReset_n  in  1  asynchronous active-low reset.
- iShader_rst_n  in  1  synchronous active-low shader reset; clears valid bits, count and ADDR.
- iChipSelect_n  in  1  host chip select, active low.
- iWrite_n  in  1  host write strobe, active low.
- iRead_n  in  1  host read strobe, active low.
- iAddress  in  32  host word address; only low 4 bits decoded, other bits ignored.
- iData  in  DataWidth  host write data.
- oData  out  DataWidth  host read data, registered.
- iFetchAddr  in  AddrWidth  PE fetch index.
- oFetchInstr  out  InstrWidth  fetched instruction, registered.
- oFetchValid  out  1  valid bit of the fetched entry, registered.
- oBusy  out  1  high while the FSM is not IDLE.

Behaviour:
- Register map (word address):
  - 0 = ADDR (low AddrWidth bits kept, rest masked).
  - 1..W = STAGE words, with W = WordsPerInstr. Word k holds bits [k*DataWidth-1:(k-1)*DataWidth].
  - W+1 = CMD: bit0 commit, bit1 readback.
  - W+2 = STATUS (read only): bit0 busy, bit1 sticky error, bits [AddrWidth+2:2] valid count (0..depth).
  - Unmapped addresses: writes ignored, reads return 0.
- Host access: an access occurs on a rising edge with iChipSelect_n=0 and a strobe low. If iWrite_n and iRead_n are both low, the write wins and oData holds.
- Reads: oData updates on the edge after the read strobe (1-cycle latency). oData holds its value otherwise.
- FSM states: IDLE, COMMIT, RB_REQ, RB_CAP.
  - IDLE -> COMMIT on a CMD write with bit0=1. Bit0 takes priority if bit0 and bit1 are both set.
  - IDLE -> RB_REQ on a CMD write with bit1=1 and bit0=0.
  - COMMIT: writes STAGE into buffer[ADDR] and sets valid[ADDR]. Count increments only if the entry was previously invalid. Returns to IDLE.
  - RB_REQ: issues a buffer read of entry ADDR. -> RB_CAP.
  - RB_CAP: loads the entry into the STAGE words. -> IDLE.
- Any host write while oBusy=1 is dropped and sets the sticky error bit. Reads are always served.
- Writing STATUS with bit1=1 clears the error bit.
- Fetch port: oFetchInstr and oFetchValid reflect iFetchAddr one cycle later. If a fetch and a COMMIT hit the same index in the same cycle, the fetch returns the old contents and old valid bit (read-before-write).
- Commit to an already-valid entry overwrites the data and leaves the count unchanged.
- iShader_rst_n low on an edge:
  - clears valid bits, count, ADDR and error;
  - forces the FSM to IDLE, aborting any pending commit or readback;
  - leaves buffer data and STAGE words untouched;
  - drops any host write in the same cycle.
- Reset values (iReset_n low), applied asynchronously:
  - oData = 0, oFetchInstr = 0, oFetchValid = 0, oBusy = 0;
  - FSM = IDLE, ADDR = 0, STAGE = 0, valid bits = 0, count = 0, error = 0.
  - Buffer contents are undefined.

Optional Feature:
- PE_LOADER_AUTO_INC_EN defined: on leaving COMMIT, ADDR becomes ADDR+1, wrapping from depth-1 to 0. Readback does not increment.
- Not defined: ADDR changes only through host writes to word address 0 and through shader reset.

Test Plan:
- Defaults. Write ADDR=0; STAGE 1..4 = DEADBEEF, CAFEBABE, 12345678, 87654321; CMD=1. Two cycles later, fetch index 0 -> oFetchInstr = 87654321_12345678_CAFEBABE_DEADBEEF, oFetchValid=1, STATUS count=1.
- Commit to index 1 (11111111..44444444), then commit index 1 again with different data -> count stays 2. Readback (ADDR=1, CMD=2), then read STAGE word 1 -> new data.
- Write STAGE word 2 in the cycle immediately after the CMD commit write (oBusy=1) -> word unchanged, STATUS bit1=1. Write STATUS=2 -> bit1=0.
- Fetch index 3 in the same cycle COMMIT writes index 3 -> returns old data with oFetchValid=0. The next fetch returns new data with oFetchValid=1.
- Pulse iShader_rst_n low after 2 commits -> count=0, oFetchValid=0 for indices 0 and 1. oFetchInstr still shows the old data.
- With PE_LOADER_AUTO_INC_EN and ADDR=31: commit twice -> entries 31 and 0 written, final ADDR reads 1. Without the macro, ADDR stays 31.

Source files
------------

// File: rtl/pe_instr_loader.sv
// pe_instr_loader
//   Memory-mapped instruction loader for a processing element. The host
//   assembles an instruction in STAGE one bus word at a time and issues a
//   CMD write to commit it into the instruction buffer at index ADDR. The
//   host can also pull a committed entry back into STAGE (readback) and
//   read a STATUS register. The PE reads the buffer through a registered
//   fetch port.
//
//   Register map (word address, only iAddress[3:0] decoded):
//     0            ADDR   (low AddrWidth bits kept)
//     1..W         STAGE  word k = bits [k*DataWidth-1:(k-1)*DataWidth]
//     W+1          CMD    bit0 commit, bit1 readback (bit0 wins)
//     W+2          STATUS bit0 busy, bit1 sticky error (write 1 to clear),
//                         bits [AddrWidth+2:2] valid count
//     other        writes ignored, reads return 0
//
//   Ports:
//     iClk, iReset_n         clock, asynchronous active-low reset
//     iShader_rst_n          synchronous active-low shader reset
//     iChipSelect_n,
//     iWrite_n, iRead_n      host strobes, active low (write wins)
//     iAddress, iData        host word address and write data
//     oData                  host read data, registered, 1-cycle latency
//     iFetchAddr             PE fetch index
//     oFetchInstr,
//     oFetchValid            fetched entry and its valid bit, registered
//     oBusy                  high while the FSM is not IDLE
//
//   Build option:
//     PE_LOADER_AUTO_INC_EN  when defined, ADDR advances by one (wrapping)
//                            after every commit.

module pe_instr_loader #(
  parameter int DataWidth     = 32,
  parameter int WordsPerInstr = 4,
  parameter int AddrWidth     = 5
) (
  input  logic                                 iClk,
  input  logic                                 iReset_n,
  input  logic                                 iShader_rst_n,
  input  logic                                 iChipSelect_n,
  input  logic                                 iWrite_n,
  input  logic                                 iRead_n,
  input  logic [31:0]                          iAddress,
  input  logic [DataWidth-1:0]                 iData,
  output logic [DataWidth-1:0]                 oData,
  input  logic [AddrWidth-1:0]                 iFetchAddr,
  output logic [DataWidth*WordsPerInstr-1:0]   oFetchInstr,
  output logic                                 oFetchValid,
  output logic                                 oBusy
);

  localparam int InstrWidth = DataWidth * WordsPerInstr;
  localparam int Depth      = 1 << AddrWidth;

  localparam logic [3:0] AddrReg    = 4'd0;
  localparam logic [3:0] CmdAddr    = 4'(WordsPerInstr + 1);
  localparam logic [3:0] StatusAddr = 4'(WordsPerInstr + 2);

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    RB_REQ,
    RB_CAP
  } state_t;

  state_t                state;
  logic [AddrWidth-1:0]  addr_reg;
  logic [InstrWidth-1:0] stage;
  logic [InstrWidth-1:0] rb_data;
  logic [Depth-1:0]      valid;
  logic [AddrWidth:0]    count;
  logic                  error;

  logic [InstrWidth-1:0] mem [Depth];

  logic [3:0]            reg_sel;
  logic                  host_wr;
  logic                  host_rd;
  logic                  busy;
  logic [DataWidth-1:0]  rd_value;
  logic                  unused_addr_bits;

  assign reg_sel          = iAddress[3:0];
  assign unused_addr_bits = ^iAddress[31:4];

  // A simultaneous write and read strobe counts as a write only.
  assign host_wr = ~iChipSelect_n & ~iWrite_n;
  assign host_rd = ~iChipSelect_n & ~iRead_n & iWrite_n;

  assign busy  = (state != IDLE);
  assign oBusy = busy;

  // Host read mux; unmapped and write-only locations read as zero.
  always_comb begin
    rd_value = '0;
    if (reg_sel == AddrReg) begin
      rd_value[AddrWidth-1:0] = addr_reg;
    end else if (reg_sel == StatusAddr) begin
      rd_value[0]             = busy;
      rd_value[1]             = error;
      rd_value[AddrWidth+2:2] = count;
    end
    for (int k = 0; k < WordsPerInstr; k++) begin
      if (reg_sel == 4'(k + 1)) begin
        rd_value = stage[k*DataWidth +: DataWidth];
      end
    end
  end

  // Buffer write port. A shader reset on the commit edge aborts the write.
  // The fetch and readback reads below use the pre-edge contents, which
  // gives read-before-write on an index collision.
  always_ff @(posedge iClk) begin
    if (state == COMMIT && iShader_rst_n) begin
      mem[addr_reg] <= stage;
    end
  end

  // Control FSM, host register file, fetch port and read data.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= IDLE;
      addr_reg    <= '0;
      stage       <= '0;
      rb_data     <= '0;
      valid       <= '0;
      count       <= '0;
      error       <= 1'b0;
      oData       <= '0;
      oFetchInstr <= '0;
      oFetchValid <= 1'b0;
    end else begin
      if (host_rd) begin
        oData <= rd_value;
      end

      oFetchInstr <= mem[iFetchAddr];
      oFetchValid <= valid[iFetchAddr];

      if (!iShader_rst_n) begin
        // Buffer data and STAGE survive a shader reset; bookkeeping does not.
        state    <= IDLE;
        addr_reg <= '0;
        valid    <= '0;
        count    <= '0;
        error    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (host_wr) begin
              if (reg_sel == AddrReg) begin
                addr_reg <= iData[AddrWidth-1:0];
              end else if (reg_sel == CmdAddr) begin
                if (iData[0]) begin
                  state <= COMMIT;
                end else if (iData[1]) begin
                  state <= RB_REQ;
                end
              end else if (reg_sel == StatusAddr) begin
                if (iData[1]) begin
                  error <= 1'b0;
                end
              end
              for (int k = 0; k < WordsPerInstr; k++) begin
                if (reg_sel == 4'(k + 1)) begin
                  stage[k*DataWidth +: DataWidth] <= iData;
                end
              end
            end
          end

          COMMIT: begin
            valid[addr_reg] <= 1'b1;
            if (!valid[addr_reg]) begin
              count <= count + 1'b1;
            end
`ifdef PE_LOADER_AUTO_INC_EN
            addr_reg <= addr_reg + 1'b1;
`else
            addr_reg <= addr_reg;
`endif
            state <= IDLE;
          end

          RB_REQ: begin
            rb_data <= mem[addr_reg];
            state   <= RB_CAP;
          end

          RB_CAP: begin
            stage <= rb_data;
            state <= IDLE;
          end

          default: state <= IDLE;
        endcase

        // Host writes are not accepted while a command is in flight.
        if (host_wr && busy) begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_instr_loader.sv
// tb_pe_instr_loader
//   Directed bench for pe_instr_loader with default parameters (32-bit bus,
//   4 words per instruction, 32-entry buffer). Stimulus pushes expected host
//   read data and fetch results into queues; a monitor pops and compares
//   them one cycle after each read strobe or tagged fetch.

module tb_pe_instr_loader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         shader_rst_n;
  logic         cs_n;
  logic         wr_n;
  logic         rd_n;
  logic [31:0]  address;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic [4:0]   fetch_addr;
  logic [127:0] fetch_instr;
  logic         fetch_valid;
  logic         busy;
  logic         fetch_req;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    string        name;
    logic [127:0] instr;
    logic         valid;
  } f_exp_t;

  rd_exp_t rd_q[$];
  f_exp_t  f_q[$];

  localparam logic [31:0] ADDR_R = 32'd0;
  localparam logic [31:0] CMD_R  = 32'd5;
  localparam logic [31:0] STAT_R = 32'd6;

  localparam logic [127:0] INSTR_A = {32'h87654321, 32'h12345678, 32'hCAFEBABE, 32'hDEADBEEF};
  localparam logic [127:0] INSTR_C = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
  localparam logic [127:0] INSTR_D = {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1};
  localparam logic [127:0] INSTR_E = {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};

  always #5 clk = ~clk;

  pe_instr_loader dut (
    .iClk          (clk),
    .iReset_n      (reset_n),
    .iShader_rst_n (shader_rst_n),
    .iChipSelect_n (cs_n),
    .iWrite_n      (wr_n),
    .iRead_n       (rd_n),
    .iAddress      (address),
    .iData         (wdata),
    .oData         (rdata),
    .iFetchAddr    (fetch_addr),
    .oFetchInstr   (fetch_instr),
    .oFetchValid   (fetch_valid),
    .oBusy         (busy)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drives one bus/fetch cycle starting at a falling edge; returns at the
  // next falling edge with strobes released.
  task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr,
                               input logic [31:0] data, input bit fetch,
                               input logic [4:0] fidx);
    cs_n       = !(wr || rd);
    wr_n       = !wr;
    rd_n       = !rd;
    address    = addr;
    wdata      = data;
    fetch_req  = fetch;
    fetch_addr = fidx;
    @(negedge clk);
    cs_n      = 1'b1;
    wr_n      = 1'b1;
    rd_n      = 1'b1;
    fetch_req = 1'b0;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data, 1'b0, 5'd0);
  endtask

  task automatic busRead(input string name, input logic [31:0] addr,
                         input logic [31:0] expected);
    rd_exp_t e;
    e.name = name;
    e.data = expected;
    rd_q.push_back(e);
    applyStimulus(1'b0, 1'b1, addr, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic fetchCheck(input string name, input logic [4:0] idx,
                            input logic [127:0] instr, input logic v);
    f_exp_t e;
    e.name  = name;
    e.instr = instr;
    e.valid = v;
    f_q.push_back(e);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, idx);
  endtask

  task automatic nop();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic writeStage(input logic [127:0] instr);
    for (int k = 0; k < 4; k++) begin
      busWrite(32'(k + 1), instr[k*32 +: 32]);
    end
  endtask

  task automatic commitAt(input logic [31:0] idx, input logic [127:0] instr);
    busWrite(ADDR_R, idx);
    writeStage(instr);
    busWrite(CMD_R, 32'd1);
    nop();
  endtask

  // Monitor: observes the bus at each rising edge and compares the
  // registered outputs shortly after.
  initial begin : monitor
    bit      saw_rd;
    bit      saw_f;
    rd_exp_t re;
    f_exp_t  fe;
    forever begin
      @(posedge clk);
      saw_rd = (!cs_n && !rd_n && wr_n);
      saw_f  = fetch_req;
      #1;
      if (saw_rd) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_read actual=%h expected=none", rdata);
        end else begin
          re = rd_q.pop_front();
          checkOutput(re.name, 128'(rdata), 128'(re.data));
        end
      end
      if (saw_f) begin
        if (f_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_fetch actual=%h expected=none", fetch_instr);
        end else begin
          fe = f_q.pop_front();
          checkOutput({fe.name, "_instr"}, fetch_instr, fe.instr);
          checkOutput({fe.name, "_valid"}, 128'(fetch_valid), 128'(fe.valid));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    reset_n      = 1'b0;
    shader_rst_n = 1'b1;
    cs_n         = 1'b1;
    wr_n         = 1'b1;
    rd_n         = 1'b1;
    address      = '0;
    wdata        = '0;
    fetch_req    = 1'b0;
    fetch_addr   = '0;

    #3;
    checkOutput("rst_odata", 128'(rdata), 128'd0);
    checkOutput("rst_finstr", fetch_instr, 128'd0);
    checkOutput("rst_fvalid", 128'(fetch_valid), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset register values");
    busRead("rst_status", STAT_R, 32'h0);
    busRead("rst_addr", ADDR_R, 32'h0);
    busRead("rst_stage1", 32'd1, 32'h0);

    $display("[TB] basic commit to index 0");
    busWrite(ADDR_R, 32'd0);
    writeStage(INSTR_A);
    busWrite(CMD_R, 32'd1);
    checkOutput("busy_in_commit", 128'(busy), 128'd1);
    nop();
    checkOutput("busy_after_commit", 128'(busy), 128'd0);
    fetchCheck("fetch0", 5'd0, INSTR_A, 1'b1);
    busRead("status_cnt1", STAT_R, 32'h4);
    busRead("status_hi_addr_bits", 32'hABCD_0016, 32'h4);
    busRead("unmapped_read", 32'd9, 32'h0);

    $display("[TB] recommit and readback");
    commitAt(32'd1, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    busRead("status_cnt2", STAT_R, 32'h8);
    commitAt(32'd1, INSTR_C);
    busRead("status_cnt2_again", STAT_R, 32'h8);
    fetchCheck("fetch1_new", 5'd1, INSTR_C, 1'b1);
    busWrite(32'd1, 32'hFFFF_FFFF);
    busWrite(ADDR_R, 32'hFFFF_FFE1);
    busRead("addr_masked", ADDR_R, 32'd1);
    busWrite(CMD_R, 32'd2);
    nop();
    nop();
    busRead("rb_stage1", 32'd1, 32'h55555555);
    busRead("rb_stage4", 32'd4, 32'h88888888);

    $display("[TB] write while busy");
    busWrite(ADDR_R, 32'd2);
    busWrite(CMD_R, 32'd1);
    busWrite(32'd2, 32'h12121212);
    busRead("busy_write_dropped", 32'd2, 32'h66666666);
    busRead("status_err", STAT_R, 32'hE);
    busWrite(STAT_R, 32'd2);
    busRead("status_err_clr", STAT_R, 32'hC);

    $display("[TB] shader reset");
    commitAt(32'd3, INSTR_D);
    busRead("status_cnt4", STAT_R, 32'h10);
    shader_rst_n = 1'b0;
    busWrite(ADDR_R, 32'd7);
    shader_rst_n = 1'b1;
    busRead("shrst_status", STAT_R, 32'h0);
    busRead("shrst_addr", ADDR_R, 32'h0);
    fetchCheck("shrst_fetch0", 5'd0, INSTR_A, 1'b0);
    fetchCheck("shrst_fetch1", 5'd1, INSTR_C, 1'b0);
    busRead("shrst_stage1", 32'd1, 32'hA1A1A1A1);

    $display("[TB] fetch and commit collision");
    busWrite(ADDR_R, 32'd3);
    writeStage(INSTR_E);
    busWrite(CMD_R, 32'd1);
    fetchCheck("collide_old", 5'd3, INSTR_D, 1'b0);
    fetchCheck("collide_new", 5'd3, INSTR_E, 1'b1);
    busRead("status_after_collide", STAT_R, 32'h4);

    $display("[TB] commits at top index");
    busWrite(ADDR_R, 32'd31);
    busWrite(CMD_R, 32'd1);
    nop();
    busWrite(CMD_R, 32'd1);
    nop();
    fetchCheck("fetch31", 5'd31, INSTR_E, 1'b1);
`ifdef PE_LOADER_AUTO_INC_EN
    busRead("addr_final", ADDR_R, 32'd1);
    fetchCheck("fetch0_final", 5'd0, INSTR_E, 1'b1);
    busRead("status_final", STAT_R, 32'hC);
`else
    busRead("addr_final", ADDR_R, 32'd31);
    fetchCheck("fetch0_final", 5'd0, INSTR_A, 1'b0);
    busRead("status_final", STAT_R, 32'h8);
`endif

    nop();
    nop();
    checkOutput("queues_drained", 128'(rd_q.size() + f_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
